// File: rtl/hub75_row_driver_if.sv
// Row-pair handoff from the pixel loader: six 1-bit colour planes per valid/ready beat.
// The driver accepts one beat per row; the loader holds the words stable while valid waits.
interface hub75_row_driver_if #(
  parameter int COLS = 64
);
  logic            s_valid;
  logic            s_ready;
  logic [COLS-1:0] red_0;
  logic [COLS-1:0] green_0;
  logic [COLS-1:0] blue_0;
  logic [COLS-1:0] red_1;
  logic [COLS-1:0] green_1;
  logic [COLS-1:0] blue_1;

  modport master (
    output s_valid, red_0, green_0, blue_0, red_1, green_1, blue_1,
    input  s_ready
  );

  modport slave (
    input  s_valid, red_0, green_0, blue_0, red_1, green_1, blue_1,
    output s_ready
  );
endinterface

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: shifts a captured row-pair out column 0 first, blanks, latches, then lights it.
// Row period is 2*CLK_DIV*COLS + 2 + OE_CYCLES cycles after the handshake; s_ready is low for all of it.
module hub75_row_driver #(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 5,
  parameter int CLK_DIV    = 2,
  parameter int OE_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  hub75_row_driver_if.slave     bus,
  output logic                  hub_r0,
  output logic                  hub_g0,
  output logic                  hub_b0,
  output logic                  hub_r1,
  output logic                  hub_g1,
  output logic                  hub_b1,
  output logic                  hub_clk,
  output logic                  hub_lat,
  output logic                  hub_oe_n,
  output logic [ROW_ADDR_W-1:0] hub_addr,
  output logic                  frame_done
);

  localparam int PER   = 2 * CLK_DIV;
  localparam int DIV_W = $clog2(PER);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int OE_W  = $clog2(OE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t                 state, state_n;
  logic [DIV_W-1:0]       div, div_n;
  logic [COL_W-1:0]       col, col_n;
  logic [OE_W-1:0]        oe_cnt, oe_cnt_n;
  logic [ROW_ADDR_W-1:0]  row_cnt, row_cnt_n;
  logic [ROW_ADDR_W-1:0]  addr_n;
  logic [5:0][COLS-1:0]   sr, sr_n;
  logic [5:0]             dat, dat_n;
  logic                   ready_n, sclk_n, lat_n, oe_off_n, fd_n;

  // Every pin is a register: the comb block computes what the next cycle should show.
  always_comb begin
    state_n   = state;
    div_n     = div;
    col_n     = col;
    oe_cnt_n  = oe_cnt;
    row_cnt_n = row_cnt;
    addr_n    = hub_addr;
    sr_n      = sr;
    dat_n     = dat;
    sclk_n    = 1'b0;
    lat_n     = 1'b0;
    oe_off_n  = 1'b1;
    fd_n      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.s_valid && bus.s_ready) begin
          state_n = SHIFT;
          div_n   = '0;
          col_n   = '0;
          sr_n    = {bus.blue_1, bus.green_1, bus.red_1, bus.blue_0, bus.green_0, bus.red_0};
          dat_n   = {bus.blue_1[0], bus.green_1[0], bus.red_1[0],
                     bus.blue_0[0], bus.green_0[0], bus.red_0[0]};
        end
      end
      SHIFT: begin
        if (div == DIV_W'(PER - 1)) begin
          // Zeros shift in, so the pins fall to 0 after the last column.
          for (int i = 0; i < 6; i++) begin
            sr_n[i]  = sr[i] >> 1;
            dat_n[i] = sr_n[i][0];
          end
          div_n = '0;
          if (col == COL_W'(COLS - 1)) begin
            state_n = BLANK;
          end else begin
            col_n = col + COL_W'(1);
          end
        end else begin
          div_n  = div + DIV_W'(1);
          sclk_n = (div + DIV_W'(1)) >= DIV_W'(CLK_DIV);
        end
      end
      BLANK: begin
        state_n = LATCH;
        lat_n   = 1'b1;
        addr_n  = row_cnt;
      end
      LATCH: begin
        state_n  = DISPLAY;
        oe_off_n = 1'b0;
        oe_cnt_n = '0;
      end
      DISPLAY: begin
        if (oe_cnt == OE_W'(OE_CYCLES - 1)) begin
          state_n   = IDLE;
          row_cnt_n = row_cnt + ROW_ADDR_W'(1);
          fd_n      = &row_cnt;
        end else begin
          oe_cnt_n = oe_cnt + OE_W'(1);
          oe_off_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      col         <= '0;
      oe_cnt      <= '0;
      row_cnt     <= '0;
      sr          <= '0;
      dat         <= '0;
      bus.s_ready <= 1'b0;
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_addr    <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      col         <= col_n;
      oe_cnt      <= oe_cnt_n;
      row_cnt     <= row_cnt_n;
      sr          <= sr_n;
      dat         <= dat_n;
      bus.s_ready <= ready_n;
      hub_clk     <= sclk_n;
      hub_lat     <= lat_n;
      hub_oe_n    <= oe_off_n;
      hub_addr    <= addr_n;
      frame_done  <= fd_n;
    end
  end

  assign hub_r0 = dat[0];
  assign hub_g0 = dat[1];
  assign hub_b0 = dat[2];
  assign hub_r1 = dat[3];
  assign hub_g1 = dat[4];
  assign hub_b1 = dat[5];

endmodule

// File: tb/tb_hub75_row_driver.sv
// Bench for hub75_row_driver: per-cycle pin comparison against a timeline model of one row period.
module tb_hub75_row_driver;
  localparam int COLS     = 64;
  localparam int AW       = 5;
  localparam int CLK_DIV  = 2;
  localparam int OE       = 256;
  localparam int S        = COLS * 2 * CLK_DIV;
  localparam int ROWS     = 1 << AW;
  localparam int ROW_GAP  = S + OE + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hub75_row_driver_if #(.COLS(COLS)) bus ();

  logic          hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
  logic          hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [AW-1:0] hub_addr;

  hub75_row_driver #(
    .COLS(COLS), .ROW_ADDR_W(AW), .CLK_DIV(CLK_DIV), .OE_CYCLES(OE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr), .frame_done(frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: m_t is the cycle offset since the handshake (-2 just reset, -1 idle and ready).
  int              m_t, m_row, m_addr, m_hs;
  logic            m_fd;
  logic [COLS-1:0] m_w[6];
  logic [COLS-1:0] pay[6];
  bit              rand_pay, track_gap;
  int              clk_edges, fd_cnt, cyc, last_hs;
  logic            prev_clk;
  logic [AW-1:0]   lat_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic new_pay();
    for (int i = 0; i < 6; i++) pay[i] = {$urandom, $urandom};
  endtask

  // Pin order: {s_ready, clk, lat, oe_n, b1,g1,r1,b0,g0,r0, addr, frame_done}
  function automatic logic [15:0] model_pins();
    logic rdy, ck, lt, oe;
    logic [5:0] d;
    int k, ph;
    rdy = (m_t == -1);
    ck  = 1'b0;
    lt  = 1'b0;
    oe  = 1'b1;
    d   = '0;
    if (m_t >= 1 && m_t <= S) begin
      k  = (m_t - 1) / (2 * CLK_DIV);
      ph = (m_t - 1) % (2 * CLK_DIV);
      ck = (ph >= CLK_DIV);
      for (int i = 0; i < 6; i++) d[i] = m_w[i][k];
    end else if (m_t == S + 2) begin
      lt = 1'b1;
    end else if (m_t >= S + 3) begin
      oe = 1'b0;
    end
    return {rdy, ck, lt, oe, d, AW'(m_addr), m_fd};
  endfunction

  task automatic cycle(input bit v, input bit r);
    logic [15:0] o;
    o = {bus.s_ready, hub_clk, hub_lat, hub_oe_n,
         hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0, hub_addr, frame_done};
    chk("pins", 64'(o), 64'(model_pins()));
    if (hub_clk === 1'b1 && prev_clk === 1'b0) clk_edges++;
    prev_clk = hub_clk;
    if (hub_lat === 1'b1) lat_q.push_back(hub_addr);
    if (frame_done === 1'b1) fd_cnt++;

    rst = r;
    bus.s_valid = v;
    // Garbage on the colour bus except in the cycle the model expects a handshake.
    if (!r && v && m_t == -1) begin
      bus.red_0 = pay[0]; bus.green_0 = pay[1]; bus.blue_0 = pay[2];
      bus.red_1 = pay[3]; bus.green_1 = pay[4]; bus.blue_1 = pay[5];
    end else begin
      bus.red_0 = {$urandom, $urandom}; bus.green_0 = {$urandom, $urandom};
      bus.blue_0 = {$urandom, $urandom}; bus.red_1 = {$urandom, $urandom};
      bus.green_1 = {$urandom, $urandom}; bus.blue_1 = {$urandom, $urandom};
    end
    if (track_gap && bus.s_ready === 1'b1 && v && !r) begin
      if (last_hs >= 0) chk("hs_gap", 64'(cyc - last_hs), 64'(ROW_GAP));
      last_hs = cyc;
    end

    if (r) begin
      m_t = -2; m_row = 0; m_addr = 0; m_fd = 1'b0; clk_edges = 0;
    end else if (m_t == -1 && v) begin
      for (int i = 0; i < 6; i++) m_w[i] = pay[i];
      m_t = 1; m_fd = 1'b0; m_hs++;
      if (rand_pay) new_pay();
    end else if (m_t < 0) begin
      m_t = -1; m_fd = 1'b0;
    end else begin
      m_t++;
      m_fd = 1'b0;
      if (m_t == S + 2) m_addr = m_row;
      if (m_t == S + 3 + OE) begin
        chk("clk_edges", 64'(clk_edges), 64'(COLS));
        clk_edges = 0;
        m_t = -1;
        m_fd = (m_row == ROWS - 1);
        m_row = (m_row + 1) % ROWS;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a0;
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.red_0 = '1; bus.green_0 = '1; bus.blue_0 = '1;
    bus.red_1 = '1; bus.green_1 = '1; bus.blue_1 = '1;
    m_t = -2; m_row = 0; m_addr = 0; m_fd = 1'b0; m_hs = 0;
    rand_pay = 0; track_gap = 0; clk_edges = 0; fd_cnt = 0;
    cyc = 0; last_hs = -1; prev_clk = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three edges with valid high, then release.
    pay[0] = 64'h1;
    for (int i = 1; i < 6; i++) pay[i] = '0;
    cycle(1, 1);
    cycle(1, 1);
    cycle(1, 0);
    cycle(1, 0);
    repeat (S + OE + 4) cycle(0, 0);

    // Bit order: column 63 last on r1, b0 solid.
    pay[0] = '0; pay[1] = '0; pay[2] = '1;
    pay[3] = 64'h8000_0000_0000_0000; pay[4] = '0; pay[5] = '0;
    cycle(1, 0);
    repeat (S + OE + 4) cycle(0, 0);

    // Continuous valid: back-to-back rows, then idle.
    rand_pay = 1;
    new_pay();
    track_gap = 1;
    repeat (3 * ROW_GAP + 2) cycle(1, 0);
    track_gap = 0;
    for (int i = 0; i < 2000 && m_t != -1; i++) cycle(0, 0);
    repeat (40) cycle(0, 0);

    // Full frame plus one row from a fresh reset.
    cycle(0, 1);
    cycle(0, 0);
    lat_q.delete();
    fd_cnt = 0;
    m_hs = 0;
    for (int i = 0; i < 40000 && m_hs < 33; i++) cycle(1, 0);
    for (int i = 0; i < 2000 && m_t != -1; i++) cycle(0, 0);
    cycle(0, 0);
    chk("lat_count", 64'(lat_q.size()), 64'(33));
    for (int i = 0; i < lat_q.size() && i < 33; i++) chk("lat_addr", 64'(lat_q[i]), 64'(i % ROWS));
    chk("frame_done_cnt", 64'(fd_cnt), 64'(1));

    // Reset in the middle of SHIFT, then one clean row.
    for (int i = 0; i < 2000 && m_t != 100; i++) cycle(1, 0);
    lat_q.delete();
    cycle(0, 1);
    for (int i = 0; i < 10 && m_t != -1; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 0; i < 2000 && m_t != -1; i++) cycle(0, 0);
    repeat (4) cycle(0, 0);
    chk("post_rst_lat_count", 64'(lat_q.size()), 64'(1));
    a0 = (lat_q.size() > 0) ? lat_q[0] : 'x;
    chk("post_rst_addr", 64'(a0), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
